// File: rtl/duck_pkg.sv
// Shared game constants, tally FSM encoding and saturation helper for the scoring logic.
package duck_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned PENDING_W = 20;
    localparam int unsigned SCORE_W   = 32;
    localparam int unsigned HIT_CNT_W = 4;
    localparam int unsigned SUM_W     = 33;

    localparam logic [STATE_W-1:0] ST_START     = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_PLAY      = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_ROUND_END = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_GAME_OVER = STATE_W'(3);

    typedef enum logic {
        IDLE  = 1'b0,
        TALLY = 1'b1
    } tally_state_t;

    // Clamp a wide intermediate sum into the pending register range.
    function automatic logic [PENDING_W-1:0] sat_pending(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] pend_max;
        pend_max = {{(SUM_W-PENDING_W){1'b0}}, {PENDING_W{1'b1}}};
        if (v > pend_max) begin
            return {PENDING_W{1'b1}};
        end
        return v[PENDING_W-1:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame_clk into the clk domain and emits one-cycle rising-edge ticks.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    output logic frame_tick_c
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign frame_tick_c = sync2 & ~sync3;

endmodule

// File: rtl/score_keeper.sv
// Accumulates hit points into a pending pool and tallies them into the displayed score once per frame.
// Optional SCORE_KEEPER_HISCORE_EN adds a hi_score register captured on entry to game over.
module score_keeper
    import duck_pkg::*;
#(
    parameter int unsigned HIT_POINTS     = 500,
    parameter int unsigned TALLY_STEP     = 100,
    parameter int unsigned PERFECT_BONUS  = 10000,
    parameter int unsigned HITS_PER_ROUND = 10,
    parameter int unsigned SCORE_MAX      = 999999999
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [STATE_W-1:0] state,
    input  logic               hit,
    input  logic [1:0]         duck_type,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
`ifdef SCORE_KEEPER_HISCORE_EN
    output logic [SCORE_W-1:0] hi_score,
`endif
    output logic               perfect
);

    localparam logic [PENDING_W-1:0] STEP_MAX   = PENDING_W'(TALLY_STEP);
    localparam logic [SUM_W-1:0]     SCORE_CEIL = SUM_W'(SCORE_MAX);
    localparam logic [HIT_CNT_W-1:0] HIT_SAT    = {HIT_CNT_W{1'b1}};

    logic                 frame_tick;
    tally_state_t         tally;
    tally_state_t         tally_next;
    logic [PENDING_W-1:0] pending;
    logic [PENDING_W-1:0] pending_next;
    logic [HIT_CNT_W-1:0] hit_count;
    logic [HIT_CNT_W-1:0] hit_count_next;
    logic [SCORE_W-1:0]   score_next;
    logic [STATE_W-1:0]   prev_state;
    logic                 accept_hit;
    logic                 enter_play;
    logic                 perfect_now;
    logic [PENDING_W-1:0] step;
    logic [SUM_W-1:0]     credit;
    logic [SUM_W-1:0]     pend_sum;
    logic [SUM_W-1:0]     score_sum;

    frame_tick_gen u_frame_tick_gen (
        .clk          (Clk),
        .rst          (Reset),
        .frame_clk    (frame_clk),
        .frame_tick_c (frame_tick)
    );

    // Next-state for the pending pool, score, hit counter and tally FSM.
    always_comb begin
        accept_hit     = hit && (state == ST_PLAY);
        enter_play     = (state == ST_PLAY) && (prev_state != ST_PLAY);
        perfect_now    = (prev_state == ST_PLAY) && (state == ST_ROUND_END) &&
                         (32'(hit_count) >= HITS_PER_ROUND);
        step           = '0;
        credit         = '0;
        pend_sum       = '0;
        score_sum      = '0;
        pending_next   = pending;
        score_next     = score;
        hit_count_next = hit_count;
        tally_next     = tally;

        if ((tally == TALLY) && frame_tick) begin
            step = (pending > STEP_MAX) ? STEP_MAX : pending;
        end

        if (accept_hit) begin
            credit = SUM_W'(HIT_POINTS) * (SUM_W'(duck_type) + SUM_W'(1));
        end
        if (perfect_now) begin
            credit = credit + SUM_W'(PERFECT_BONUS);
        end

        // Tick and hit in the same cycle both land: subtract the step, then add the credit.
        pend_sum     = SUM_W'(pending - step) + credit;
        pending_next = sat_pending(pend_sum);

        // Hitting the ceiling discards whatever is still waiting to be tallied.
        score_sum = SUM_W'(score) + SUM_W'(step);
        if (score_sum > SCORE_CEIL) begin
            score_next   = SCORE_W'(SCORE_MAX);
            pending_next = '0;
        end else begin
            score_next = score_sum[SCORE_W-1:0];
        end

        if (enter_play) begin
            hit_count_next = accept_hit ? HIT_CNT_W'(1) : '0;
        end else if (accept_hit && (hit_count != HIT_SAT)) begin
            hit_count_next = hit_count + HIT_CNT_W'(1);
        end

        case (tally)
            IDLE:    tally_next = (pending != '0) ? TALLY : IDLE;
            TALLY:   tally_next = (pending_next == '0) ? IDLE : TALLY;
            default: tally_next = IDLE;
        endcase

        // The start screen pins everything to zero and ignores hits.
        if (state == ST_START) begin
            pending_next   = '0;
            score_next     = '0;
            hit_count_next = '0;
            tally_next     = IDLE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tally      <= IDLE;
            pending    <= '0;
            hit_count  <= '0;
            score      <= '0;
            busy       <= 1'b0;
            perfect    <= 1'b0;
            prev_state <= ST_START;
        end else begin
            tally      <= tally_next;
            pending    <= pending_next;
            hit_count  <= hit_count_next;
            score      <= score_next;
            busy       <= (tally_next == TALLY);
            perfect    <= perfect_now;
            prev_state <= state;
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    // Capture a new best on the first game-over cycle; survives the return to start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_score <= '0;
        end else if ((state == ST_GAME_OVER) && (prev_state != ST_GAME_OVER) &&
                     (score > hi_score)) begin
            hi_score <= score;
        end
    end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: default instance plus a short-step, low-ceiling instance.
module tb_score_keeper;

    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_ROUND_END = 3'd2;
    localparam logic [2:0] ST_GAME_OVER = 3'd3;

    logic        clk;
    logic        rst;
    logic        a_frame, b_frame;
    logic [2:0]  a_state, b_state;
    logic        a_hit, b_hit;
    logic [1:0]  a_dt, b_dt;
    logic [31:0] a_score, b_score;
    logic        a_busy, b_busy;
    logic        a_perfect, b_perfect;
`ifdef SCORE_KEEPER_HISCORE_EN
    logic [31:0] a_hi, b_hi;
`endif

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (a_frame),
        .state     (a_state),
        .hit       (a_hit),
        .duck_type (a_dt),
        .score     (a_score),
        .busy      (a_busy),
`ifdef SCORE_KEEPER_HISCORE_EN
        .hi_score  (a_hi),
`endif
        .perfect   (a_perfect)
    );

    // Step of 150 reaches a 50-point remainder; ceiling of 1399 makes the clamp reachable quickly.
    score_keeper #(
        .TALLY_STEP (150),
        .SCORE_MAX  (1399)
    ) dut_b (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (b_frame),
        .state     (b_state),
        .hit       (b_hit),
        .duck_type (b_dt),
        .score     (b_score),
        .busy      (b_busy),
`ifdef SCORE_KEEPER_HISCORE_EN
        .hi_score  (b_hi),
`endif
        .perfect   (b_perfect)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_pulse(input bit on_b);
        if (on_b) b_frame = 1'b1; else a_frame = 1'b1;
        step_clk(4);
        if (on_b) b_frame = 1'b0; else a_frame = 1'b0;
        step_clk(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step_clk(2);
        checks++;
        if (a_score !== 32'd0 || a_busy !== 1'b0 || a_perfect !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs score=%0d busy=%0b perfect=%0b want 0/0/0", a_score, a_busy, a_perfect);
        end
        checks++;
        if (dut.pending !== 20'd0 || dut_b.pending !== 20'd0) begin
            errors++;
            $display("FAIL reset_pending got %0d/%0d want 0", dut.pending, dut_b.pending);
        end
        rst = 1'b0;
        step_clk(1);
    endtask

    task automatic test_tally;
        a_state = ST_PLAY;
        step_clk(1);
        a_hit = 1'b1; a_dt = 2'd1;
        step_clk(1);
        a_hit = 1'b0; a_dt = 2'd0;
        checks++;
        if (dut.pending !== 20'd1000) begin
            errors++;
            $display("FAIL hit_points got %0d want 1000", dut.pending);
        end
        step_clk(1);
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_enter got %0b want 1", a_busy);
        end
        // Score must move one clock after the tick cycle, not during it.
        a_frame = 1'b1;
        step_clk(2);
        checks++;
        if (a_score !== 32'd0) begin
            errors++;
            $display("FAIL tick_latency_early got %0d want 0", a_score);
        end
        step_clk(1);
        checks++;
        if (a_score !== 32'd100) begin
            errors++;
            $display("FAIL tick_latency got %0d want 100", a_score);
        end
        a_frame = 1'b0;
        step_clk(3);
        repeat (4) frame_pulse(1'b0);
        checks++;
        if (a_score !== 32'd500 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL tally_half score=%0d busy=%0b want 500/1", a_score, a_busy);
        end
        repeat (5) frame_pulse(1'b0);
        checks++;
        if (a_score !== 32'd1000 || a_busy !== 1'b0 || dut.pending !== 20'd0) begin
            errors++;
            $display("FAIL tally_done score=%0d busy=%0b pending=%0d want 1000/0/0", a_score, a_busy, dut.pending);
        end
        frame_pulse(1'b0);
        checks++;
        if (a_score !== 32'd1000) begin
            errors++;
            $display("FAIL idle_no_transfer got %0d want 1000", a_score);
        end
    endtask

    task automatic test_reset_mid_tally;
        a_hit = 1'b1; a_dt = 2'd0;
        step_clk(1);
        a_hit = 1'b0;
        step_clk(1);
        repeat (2) frame_pulse(1'b0);
        checks++;
        if (dut.pending !== 20'd300 || a_busy !== 1'b1 || a_score !== 32'd1200) begin
            errors++;
            $display("FAIL pre_reset pending=%0d busy=%0b score=%0d want 300/1/1200", dut.pending, a_busy, a_score);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_score !== 32'd0 || dut.pending !== 20'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tally score=%0d pending=%0d busy=%0b want 0/0/0", a_score, dut.pending, a_busy);
        end
        step_clk(1);
        rst = 1'b0;
        step_clk(1);
    endtask

    task automatic test_ignored_hits;
        a_hit = 1'b1; a_dt = 2'd0;
        step_clk(1);
        a_hit = 1'b0;
        step_clk(1);
        repeat (2) frame_pulse(1'b0);
        a_state = ST_ROUND_END;
        step_clk(1);
        a_hit = 1'b1; a_dt = 2'd3;
        step_clk(1);
        a_hit = 1'b0;
        step_clk(1);
        checks++;
        if (dut.pending !== 20'd300 || a_score !== 32'd200 || a_perfect !== 1'b0) begin
            errors++;
            $display("FAIL round_end_hit pending=%0d score=%0d perfect=%0b want 300/200/0", dut.pending, a_score, a_perfect);
        end
        a_state = ST_START;
        step_clk(1);
        checks++;
        if (a_score !== 32'd0 || dut.pending !== 20'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_clear score=%0d pending=%0d busy=%0b want 0/0/0", a_score, dut.pending, a_busy);
        end
        a_hit = 1'b1; a_dt = 2'd2;
        step_clk(2);
        a_hit = 1'b0;
        step_clk(1);
        checks++;
        if (dut.pending !== 20'd0 || a_score !== 32'd0) begin
            errors++;
            $display("FAIL start_hit pending=%0d score=%0d want 0/0", dut.pending, a_score);
        end
    endtask

    task automatic test_perfect;
        int pulses;
        a_state = ST_PLAY;
        step_clk(1);
        a_hit = 1'b1; a_dt = 2'd0;
        step_clk(10);
        a_hit = 1'b0;
        a_state = ST_ROUND_END;
        step_clk(1);
        checks++;
        if (a_perfect !== 1'b1 || dut.pending !== 20'd15000) begin
            errors++;
            $display("FAIL perfect_10 perfect=%0b pending=%0d want 1/15000", a_perfect, dut.pending);
        end
        pulses = 0;
        repeat (5) begin
            step_clk(1);
            if (a_perfect) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL perfect_single extra_pulses=%0d want 0", pulses);
        end
        a_state = ST_START;
        step_clk(1);
        a_state = ST_PLAY;
        step_clk(1);
        a_hit = 1'b1;
        step_clk(9);
        a_hit = 1'b0;
        a_state = ST_ROUND_END;
        pulses = 0;
        repeat (5) begin
            step_clk(1);
            if (a_perfect) pulses++;
        end
        checks++;
        if (pulses !== 0 || dut.pending !== 20'd4500) begin
            errors++;
            $display("FAIL perfect_9 pulses=%0d pending=%0d want 0/4500", pulses, dut.pending);
        end
    endtask

    task automatic test_same_cycle;
        b_state = ST_PLAY;
        step_clk(1);
        b_hit = 1'b1; b_dt = 2'd0;
        step_clk(1);
        b_hit = 1'b0;
        step_clk(1);
        repeat (3) frame_pulse(1'b1);
        checks++;
        if (b_score !== 32'd450 || dut_b.pending !== 20'd50) begin
            errors++;
            $display("FAIL b_pre score=%0d pending=%0d want 450/50", b_score, dut_b.pending);
        end
        b_frame = 1'b1;
        step_clk(2);
        b_hit = 1'b1; b_dt = 2'd0;
        step_clk(1);
        b_hit = 1'b0;
        checks++;
        if (b_score !== 32'd500 || dut_b.pending !== 20'd500 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle score=%0d pending=%0d busy=%0b want 500/500/1", b_score, dut_b.pending, b_busy);
        end
        b_frame = 1'b0;
        step_clk(3);
    endtask

    task automatic test_clamp;
        repeat (4) frame_pulse(1'b1);
        checks++;
        if (b_score !== 32'd1000 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL b_drain score=%0d busy=%0b want 1000/0", b_score, b_busy);
        end
        b_hit = 1'b1; b_dt = 2'd1;
        step_clk(1);
        b_hit = 1'b0;
        step_clk(1);
        repeat (2) frame_pulse(1'b1);
        checks++;
        if (b_score !== 32'd1300 || dut_b.pending !== 20'd700) begin
            errors++;
            $display("FAIL pre_clamp score=%0d pending=%0d want 1300/700", b_score, dut_b.pending);
        end
        frame_pulse(1'b1);
        checks++;
        if (b_score !== 32'd1399 || dut_b.pending !== 20'd0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL clamp score=%0d pending=%0d busy=%0b want 1399/0/0", b_score, dut_b.pending, b_busy);
        end
        b_hit = 1'b1; b_dt = 2'd0;
        step_clk(1);
        b_hit = 1'b0;
        step_clk(1);
        frame_pulse(1'b1);
        checks++;
        if (b_score !== 32'd1399 || dut_b.pending !== 20'd0) begin
            errors++;
            $display("FAIL clamp_again score=%0d pending=%0d want 1399/0", b_score, dut_b.pending);
        end
    endtask

`ifdef SCORE_KEEPER_HISCORE_EN
    task automatic test_hiscore;
        b_state = ST_GAME_OVER;
        step_clk(2);
        checks++;
        if (b_hi !== 32'd1399) begin
            errors++;
            $display("FAIL hiscore_load got %0d want 1399", b_hi);
        end
        b_state = ST_START;
        step_clk(2);
        checks++;
        if (b_hi !== 32'd1399 || b_score !== 32'd0) begin
            errors++;
            $display("FAIL hiscore_keep hi=%0d score=%0d want 1399/0", b_hi, b_score);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        a_frame = 1'b0; b_frame = 1'b0;
        a_state = ST_START; b_state = ST_START;
        a_hit = 1'b0; b_hit = 1'b0;
        a_dt = 2'd0; b_dt = 2'd0;
        test_reset();
        test_tally();
        test_reset_mid_tally();
        test_ignored_hits();
        test_perfect();
        test_same_cycle();
        test_clamp();
`ifdef SCORE_KEEPER_HISCORE_EN
        test_hiscore();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter HIT_POINTS, default 500, base points per hit.
REQ-002 SHALL have parameter TALLY_STEP, default 100, max points moved from pending to score per frame.
REQ-003 SHALL have parameter PERFECT_BONUS, default 10000, bonus for a perfect round.
REQ-004 SHALL have parameter HITS_PER_ROUND, default 10, hits that make a round perfect.
REQ-005 SHALL have parameter SCORE_MAX, default 999999999, score ceiling (9 display digits).
REQ-006 SHALL have port Clk  input  1  50 MHz system clock.
REQ-007 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port frame_clk  input  1  ~60 Hz frame indicator, asynchronous to Clk.
REQ-009 SHALL have port state  input  3  game state (ST_START=0, ST_PLAY=1, ST_ROUND_END=2, ST_GAME_OVER=3).
REQ-010 SHALL have port hit  input  1  one-Clk pulse per duck hit.
REQ-011 SHALL have port duck_type  input  2  points multiplier minus one.
REQ-012 SHALL have port score  output  32  displayed score, feeds score_display.
REQ-013 SHALL have port busy  output  1  high while tally FSM in TALLY.
REQ-014 SHALL have port perfect  output  1  one-Clk pulse when perfect bonus is credited.

Function
REQ-015 SHALL synchronise frame_clk through two flops; frame_tick = sync2 & ~sync3, one Clk wide per rising edge.
REQ-016 SHALL accept hit only when state==ST_PLAY; add HIT_POINTS*(duck_type+1) to 20-bit pending register, saturating at 2^20-1.
REQ-017 SHALL count accepted hits in 4-bit hit_count, saturating at 15; cleared on the cycle state enters ST_PLAY.
REQ-018 SHALL implement FSM IDLE/TALLY: IDLE->TALLY when pending!=0; TALLY->IDLE when pending==0 after an update.
REQ-019 SHALL, in TALLY on frame_tick, move min(TALLY_STEP, pending) from pending to score.
REQ-020 SHALL apply hit and frame_tick in the same cycle together: pending_next = pending - step + points.
REQ-021 SHALL clamp score at SCORE_MAX; when clamping occurs pending SHALL be cleared to 0.
REQ-022 SHALL, on the cycle state changes ST_PLAY->ST_ROUND_END with hit_count>=HITS_PER_ROUND, add PERFECT_BONUS to pending and pulse perfect.
REQ-023 SHALL, while state==ST_START, hold score, pending, hit_count at 0 and FSM in IDLE; hits ignored.
REQ-024 SHALL register all outputs; score changes one Clk after the frame_tick cycle.

Reset
REQ-025 SHALL on Reset drive score=0, busy=0, perfect=0, pending=0, hit_count=0, FSM=IDLE, sync flops=0, prev state=ST_START.
REQ-026 SHALL abort any tally in progress on Reset; no partial transfer completes.

Configuration
REQ-027 SHALL, with SCORE_KEEPER_HISCORE_EN defined, add output hi_score (32 bits, reset 0), loaded with score on entry to ST_GAME_OVER when score>hi_score, not cleared in ST_START.
REQ-028 SHALL, without SCORE_KEEPER_HISCORE_EN, omit hi_score port and its register entirely.

Structure
REQ-029 SHALL take game-state constants ST_* and FSM typedef tally_state_t from shared package duck_pkg.
REQ-030 SHALL implement the frame_clk synchroniser/edge detector as sub-module frame_tick_gen.

Verification
REQ-031 Reset mid-TALLY (pending=300) -> score=0, pending=0, busy=0 next cycle.
REQ-032 ST_PLAY, hit with duck_type=1 -> pending=1000; after 10 frame_ticks score=1000, busy=0.
REQ-033 hit (duck_type=0) same cycle as frame_tick with pending=50 -> score+=50, pending=500.
REQ-034 10 hits then ST_PLAY->ST_ROUND_END -> perfect pulses once, pending +=10000; 9 hits -> no pulse.
REQ-035 score=999999900, pending=500 -> after ticks score=999999999, pending=0, busy=0.
REQ-036 hit while state=ST_ROUND_END or ST_START -> pending unchanged, score unchanged.
